gray_ptr_receiver: RTL

//  Receiving end of a Gray-coded counter/pointer crossing from a foreign clock domain.

---
 rtl/gray_ptr_receiver_pkg.sv | 26 ++
 rtl/gray_ptr_receiver_if.sv | 36 +++
 rtl/gray_sync_chain.sv | 31 +++
 rtl/gray_ptr_receiver.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/gray_ptr_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_ptr_receiver_pkg
//  Description : Shared FSM state encodings and a popcount helper for the
//                Gray pointer receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_ptr_receiver_pkg;

  // Receiver FSM: wait for the synchronizer to fill, capture a baseline, run.
  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_BASE = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // Number of set bits in a word; callers zero-extend narrower vectors.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_ptr_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_ptr_receiver_if
//  Description : Gray input word, clear request and change-report outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gray_ptr_receiver_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     iwv_gray;
  logic                 iw_clear;
  logic [WIDTH-1:0]     owv_gray;
  logic [WIDTH-1:0]     owv_bin;
  logic                 ow_valid;
  logic [WIDTH-1:0]     owv_delta;
  logic                 ow_up;
  logic                 ow_skip;
  logic                 ow_err_sticky;
  logic [CNT_WIDTH-1:0] owv_events;

  // Consumer side: drives the Gray word and clear, observes reports.
  modport master (
    output iwv_gray, iw_clear,
    input  owv_gray, owv_bin, ow_valid, owv_delta, ow_up, ow_skip,
           ow_err_sticky, owv_events
  );

  // Receiver side.
  modport slave (
    input  iwv_gray, iw_clear,
    output owv_gray, owv_bin, ow_valid, owv_delta, ow_up, ow_skip,
           ow_err_sticky, owv_events
  );
endinterface
`default_nettype wire

// File: rtl/gray_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : gray_sync_chain
//  Description : Multi-flop synchronizer for an asynchronous Gray word.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_sync_chain #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             iw_clk,
  input  wire logic             iw_reset_n,
  input  wire logic [WIDTH-1:0] iwv_gray,
  output logic      [WIDTH-1:0] owv_gray
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

  // Shift the foreign word through SYNC_STAGES flops; stage 0 is metastable-prone.
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], iwv_gray};
    end
  end

  assign owv_gray = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gray_ptr_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : gray_ptr_receiver
//  Description : Synchronizes a foreign-domain Gray pointer, decodes it and
//                reports each change with step, direction, skip flag and a
//                saturating event count.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_ptr_receiver
  import gray_ptr_receiver_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  wire logic          iw_clk,
  input  wire logic          iw_reset_n,
  gray_ptr_receiver_if.slave bus
);

  localparam int                c_FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(SYNC_STAGES - 1);

  logic [WIDTH-1:0]     w_sync_gray;
  logic [WIDTH-1:0]     w_sync_bin;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_delta;
  logic                 w_changed;
  logic                 w_multi;
  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [c_FILL_W-1:0]  r_fill;
  logic                 w_capture;
  logic                 w_report;
  logic [WIDTH-1:0]     r_prev_gray;
  logic [WIDTH-1:0]     r_prev_bin;
  logic                 r_valid;
  logic                 r_skip;
  logic [WIDTH-1:0]     r_delta;
  logic                 r_up;
  logic                 r_sticky;
  logic [CNT_WIDTH-1:0] r_events;

  gray_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .iw_clk     (iw_clk),
    .iw_reset_n (iw_reset_n),
    .iwv_gray   (bus.iwv_gray),
    .owv_gray   (w_sync_gray)
  );

  // Gray-to-binary: each binary bit is the XOR of all Gray bits from the MSB down.
  for (genvar i = 0; i < WIDTH; i++) begin : g_decode
    assign w_sync_bin[i] = ^w_sync_gray[WIDTH-1:i];
  end

  // Modular step and bit-distance against the last reported sample.
  assign w_diff    = w_sync_gray ^ r_prev_gray;
  assign w_changed = |w_diff;
  assign w_multi   = popcount(32'(w_diff)) > 6'd1;
  assign w_delta   = w_sync_bin - r_prev_bin;

  // FSM state register plus fill counter that times the synchronizer warm-up.
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      r_state <= S_FILL;
      r_fill  <= '0;
    end else begin
      r_state <= w_next_state;
      r_fill  <= (r_state == S_FILL) ? r_fill + 1'b1 : '0;
    end
  end

  // Next-state: a clear while running forces a fresh baseline capture.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FILL:  if (r_fill == c_FILL_LAST) w_next_state = S_BASE;
      S_BASE:  w_next_state = S_RUN;
      S_RUN:   if (bus.iw_clear) w_next_state = S_BASE;
      default: w_next_state = S_FILL;
    endcase
  end

  // FSM outputs: baseline capture, or a change report unless clear overrides it.
  always_comb begin
    w_capture = 1'b0;
    w_report  = 1'b0;
    case (r_state)
      S_BASE:  w_capture = 1'b1;
      S_RUN:   w_report  = w_changed && !bus.iw_clear;
      default: ;
    endcase
  end

  // Report datapath: pulses, held step/direction, sticky error and saturating count.
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      r_prev_gray <= '0;
      r_prev_bin  <= '0;
      r_valid     <= 1'b0;
      r_skip      <= 1'b0;
      r_delta     <= '0;
      r_up        <= 1'b0;
      r_sticky    <= 1'b0;
      r_events    <= '0;
    end else begin
      r_valid <= w_report;
      r_skip  <= w_report && w_multi;
      if (w_capture || w_report) begin
        r_prev_gray <= w_sync_gray;
        r_prev_bin  <= w_sync_bin;
      end
      if (w_report) begin
        r_delta <= w_delta;
        r_up    <= ~w_delta[WIDTH-1];
      end
      if (bus.iw_clear) begin
        r_sticky <= 1'b0;
        r_events <= '0;
      end else if (w_report) begin
        if (w_multi) r_sticky <= 1'b1;
        if (r_events != {CNT_WIDTH{1'b1}}) r_events <= r_events + 1'b1;
      end
    end
  end

  assign bus.owv_gray      = r_prev_gray;
  assign bus.owv_bin       = r_prev_bin;
  assign bus.ow_valid      = r_valid;
  assign bus.owv_delta     = r_delta;
  assign bus.ow_up         = r_up;
  assign bus.ow_skip       = r_skip;
  assign bus.ow_err_sticky = r_sticky;
  assign bus.owv_events    = r_events;

endmodule
`default_nettype wire
